// File: rtl/axi4_lite_sfp_mch.sv
// axi4_lite_sfp_mch: AXI4-Lite register block for an SFP link (master cmd/rsp, slave cmd/rsp)
// with a per-slave status-word mirror and a maskable level interrupt.
module axi4_lite_sfp_mch #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_SLAVE_NUM = 1,
  parameter int C_STAT_NUM = 9,
  parameter int C_S_AXI_ADDR_WIDTH = $clog2(16 + 16 * C_SLAVE_NUM) + 2
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [3:0]                        S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              o_sfp_en,
  output logic [1:0]                        o_sfp_id,
  output logic [31:0]                       o_m_sfp_cmd,
  output logic [31:0]                       o_m_sfp_data,
  output logic                              o_m_sfp_flag,
  input  logic [63:0]                       i_m_sfp_rsp,
  input  logic                              i_m_sfp_rsp_valid,
  input  logic [31:0]                       i_s_sfp_cmd,
  input  logic [31:0]                       i_s_sfp_data,
  input  logic                              i_s_sfp_cmd_valid,
  output logic [63:0]                       o_s_sfp_rsp,
  output logic                              o_s_sfp_rsp_flag,
  input  logic [C_SLAVE_NUM*C_STAT_NUM*32-1:0] i_stat,
  output logic                              o_irq
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int NW = 2 ** (AW - 2);
  logic [AW-3:0] widx, ridx;
  logic wr, rd, acc;
  logic [15:0] we;
  logic [3:0] irq_stat, irq_en, irq_set, w1c;
  logic [63:0] m_rsp;
  logic [31:0] s_cmd, s_data;
  logic [C_SLAVE_NUM*C_STAT_NUM*32-1:0] stat_q;
  logic [31:0] rd_word [0:NW-1];
  logic unused;
  function automatic logic [31:0] wmask(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    return {s[3] ? d[31:24] : o[31:24], s[2] ? d[23:16] : o[23:16],
            s[1] ? d[15:8] : o[15:8], s[0] ? d[7:0] : o[7:0]};
  endfunction
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign widx = S_AXI_AWADDR[AW-1:2];
  assign ridx = S_AXI_ARADDR[AW-1:2];
  assign acc = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_AWREADY & ~S_AXI_BVALID;
  assign wr = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd = S_AXI_ARREADY & S_AXI_ARVALID;
  assign we = (wr && widx[AW-3:4] == '0) ? 16'd1 << widx[3:0] : 16'd0;
  assign w1c = (we[8] & S_AXI_WSTRB[0]) ? S_AXI_WDATA[3:0] : 4'd0;
  assign irq_set = {i_s_sfp_cmd_valid & irq_stat[1], i_m_sfp_rsp_valid & irq_stat[0],
                    i_s_sfp_cmd_valid, i_m_sfp_rsp_valid};
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign rd_word[0] = {31'd0, o_sfp_en};
  assign rd_word[1] = {30'd0, o_sfp_id};
  assign rd_word[2] = o_m_sfp_cmd;
  assign rd_word[3] = o_m_sfp_data;
  assign rd_word[4] = 32'd0;
  assign rd_word[5] = o_s_sfp_rsp[31:0];
  assign rd_word[6] = o_s_sfp_rsp[63:32];
  assign rd_word[7] = 32'd0;
  assign rd_word[8] = {28'd0, irq_stat};
  assign rd_word[9] = {28'd0, irq_en};
  assign rd_word[10] = m_rsp[31:0];
  assign rd_word[11] = m_rsp[63:32];
  assign rd_word[12] = s_cmd;
  assign rd_word[13] = s_data;
  assign rd_word[14] = 32'h0002_0000;
  assign rd_word[15] = 32'd0;
  // Each slave owns a 16-word window; words past C_STAT_NUM or past the last slave read as 0.
  for (genvar g = 16; g < NW; g++) begin : g_stat
    if ((g - 16) / 16 < C_SLAVE_NUM && (g - 16) % 16 < C_STAT_NUM) begin : g_on
      assign rd_word[g] = stat_q[(((g - 16) / 16) * C_STAT_NUM + (g - 16) % 16) * 32 +: 32];
    end else begin : g_off
      assign rd_word[g] = 32'd0;
    end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      o_sfp_en <= 1'b0;
      o_sfp_id <= 2'd0;
      o_m_sfp_cmd <= 32'd0;
      o_m_sfp_data <= 32'd0;
      o_m_sfp_flag <= 1'b0;
      o_s_sfp_rsp <= 64'd0;
      o_s_sfp_rsp_flag <= 1'b0;
      o_irq <= 1'b0;
      irq_stat <= 4'd0;
      irq_en <= 4'd0;
      m_rsp <= 64'd0;
      s_cmd <= 32'd0;
      s_data <= 32'd0;
      stat_q <= '0;
    end else begin
      S_AXI_AWREADY <= acc;
      S_AXI_WREADY <= acc;
      S_AXI_BVALID <= wr | (S_AXI_BVALID & ~S_AXI_BREADY);
      S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_ARREADY & ~S_AXI_RVALID;
      S_AXI_RVALID <= rd | (S_AXI_RVALID & ~S_AXI_RREADY);
      if (rd) S_AXI_RDATA <= rd_word[ridx];
      if (we[0] & S_AXI_WSTRB[0]) o_sfp_en <= S_AXI_WDATA[0];
      if (we[1] & S_AXI_WSTRB[0]) o_sfp_id <= S_AXI_WDATA[1:0];
      if (we[2]) o_m_sfp_cmd <= wmask(o_m_sfp_cmd, S_AXI_WDATA, S_AXI_WSTRB);
      if (we[3]) o_m_sfp_data <= wmask(o_m_sfp_data, S_AXI_WDATA, S_AXI_WSTRB);
      if (we[5]) o_s_sfp_rsp[31:0] <= wmask(o_s_sfp_rsp[31:0], S_AXI_WDATA, S_AXI_WSTRB);
      if (we[6]) o_s_sfp_rsp[63:32] <= wmask(o_s_sfp_rsp[63:32], S_AXI_WDATA, S_AXI_WSTRB);
      if (we[9] & S_AXI_WSTRB[0]) irq_en <= S_AXI_WDATA[3:0];
      o_m_sfp_flag <= we[4] & S_AXI_WDATA[0];
      o_s_sfp_rsp_flag <= we[7] & S_AXI_WDATA[0];
      irq_stat <= (irq_stat & ~w1c) | irq_set;
      o_irq <= |(irq_stat & irq_en);
      if (i_m_sfp_rsp_valid) m_rsp <= i_m_sfp_rsp;
      if (i_s_sfp_cmd_valid) s_cmd <= i_s_sfp_cmd;
      if (i_s_sfp_cmd_valid) s_data <= i_s_sfp_data;
      stat_q <= i_stat;
    end
  end
endmodule

// File: tb/tb_axi4_lite_sfp_mch.sv
// tb_axi4_lite_sfp_mch: directed and random AXI-Lite traffic against a register-map model.
module tb_axi4_lite_sfp_mch;
  localparam int SN = 2;
  localparam int STN = 9;
  localparam int AW = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic o_sfp_en, o_m_sfp_flag, o_s_sfp_rsp_flag, o_irq;
  logic [1:0] o_sfp_id;
  logic [31:0] o_m_sfp_cmd, o_m_sfp_data;
  logic [63:0] o_s_sfp_rsp;
  logic [63:0] m_rsp_in = '0;
  logic m_rsp_v = 0, s_cmd_v = 0;
  logic [31:0] s_cmd_in = '0, s_data_in = '0;
  logic [SN*STN*32-1:0] i_stat;
  logic [31:0] stv [0:SN*STN-1];
  logic [31:0] mr [0:15];
  logic flag_m, flag_m2, flag_s, flag_s2;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < SN * STN; i++) i_stat[i*32 +: 32] = stv[i];

  axi4_lite_sfp_mch #(.C_S_AXI_DATA_WIDTH(32), .C_SLAVE_NUM(SN), .C_STAT_NUM(STN)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .o_sfp_en(o_sfp_en), .o_sfp_id(o_sfp_id), .o_m_sfp_cmd(o_m_sfp_cmd), .o_m_sfp_data(o_m_sfp_data),
    .o_m_sfp_flag(o_m_sfp_flag), .i_m_sfp_rsp(m_rsp_in), .i_m_sfp_rsp_valid(m_rsp_v),
    .i_s_sfp_cmd(s_cmd_in), .i_s_sfp_data(s_data_in), .i_s_sfp_cmd_valid(s_cmd_v),
    .o_s_sfp_rsp(o_s_sfp_rsp), .o_s_sfp_rsp_flag(o_s_sfp_rsp_flag), .i_stat(i_stat), .o_irq(o_irq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 32'd0;
    mr[14] = 32'h0002_0000;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    case (idx)
      0: mr[0] = merge(mr[0], d, s) & 32'h1;
      1: mr[1] = merge(mr[1], d, s) & 32'h3;
      2, 3, 5, 6: mr[idx] = merge(mr[idx], d, s);
      8: if (s[0]) mr[8] = mr[8] & ~(d & 32'hF);
      9: mr[9] = merge(mr[9], d, s) & 32'hF;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] exp_rd(input int idx);
    int s, k;
    if (idx < 16) return (idx == 4 || idx == 7 || idx == 15) ? 32'd0 : mr[idx];
    s = (idx - 16) / 16;
    k = (idx - 16) % 16;
    return (s < SN && k < STN) ? stv[s*STN + k] : 32'd0;
  endfunction

  task automatic chk_out();
    chk("en", o_sfp_en, mr[0][0]);
    chk("id", o_sfp_id, mr[1][1:0]);
    chk("m_cmd", o_m_sfp_cmd, mr[2]);
    chk("m_data", o_m_sfp_data, mr[3]);
    chk("s_rsp", o_s_sfp_rsp, {mr[6], mr[5]});
  endtask

  task automatic axi_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input bit sync_s);
    int n = 0;
    logic ovr;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) chk("aw_timeout", awready, 1);
    else chk("wready", wready, 1);
    if (sync_s) begin
      s_cmd_in = $urandom; s_data_in = $urandom; s_cmd_v = 1;
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; s_cmd_v = 0;
    ovr = mr[8][1];
    model_write(int'(a[AW-1:2]), d, s);
    if (sync_s) begin
      mr[12] = s_cmd_in; mr[13] = s_data_in;
      mr[8] = mr[8] | 32'h2 | (ovr ? 32'h8 : 32'h0);
    end
    flag_m = o_m_sfp_flag; flag_s = o_s_sfp_rsp_flag;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    flag_m2 = o_m_sfp_flag; flag_s2 = o_s_sfp_rsp_flag;
    chk("bdone", bvalid, 0);
  endtask

  task automatic axi_rd(input logic [AW-1:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) chk("ar_timeout", arready, 1);
    @(negedge clk);
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    chk("rresp", rresp, 0);
    d = rdata;
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("rdone", rvalid, 0);
  endtask

  task automatic pulse_m();
    @(negedge clk);
    m_rsp_in = {$urandom, $urandom}; m_rsp_v = 1;
    mr[10] = m_rsp_in[31:0]; mr[11] = m_rsp_in[63:32];
    mr[8] = mr[8] | 32'h1 | (mr[8][0] ? 32'h4 : 32'h0);
    @(negedge clk);
    m_rsp_v = 0;
  endtask

  task automatic pulse_s();
    @(negedge clk);
    s_cmd_in = $urandom; s_data_in = $urandom; s_cmd_v = 1;
    mr[12] = s_cmd_in; mr[13] = s_data_in;
    mr[8] = mr[8] | 32'h2 | (mr[8][1] ? 32'h8 : 32'h0);
    @(negedge clk);
    s_cmd_v = 0;
  endtask

  initial begin
    logic [31:0] d;
    int idx;
    logic [3:0] s;
    for (int i = 0; i < SN * STN; i++) stv[i] = $urandom;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_irq", o_irq, 0);
    chk_out();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      axi_rd(AW'(i * 4), d);
      chk("rst_rd", d, exp_rd(i));
    end
    axi_wr(8'h14, 32'hFFFF_FFFF, 4'b0010, 0);
    chk("strb_lo", o_s_sfp_rsp[31:0], 32'h0000_FF00);
    axi_wr(8'h08, 32'h1234_5678, 4'hF, 0);
    chk("m_cmd_dir", o_m_sfp_cmd, 32'h1234_5678);
    axi_wr(8'h10, 32'h1, 4'hF, 0);
    chk("m_flag_on", flag_m, 1);
    chk("m_flag_off", flag_m2, 0);
    axi_rd(8'h10, d);
    chk("m_go_rd", d, 0);
    pulse_m();
    pulse_m();
    axi_rd(8'h20, d);
    chk("irq_ovr", d, 32'h5);
    axi_wr(8'h20, 32'h5, 4'hF, 0);
    axi_rd(8'h20, d);
    chk("irq_clr", d, 32'h0);
    pulse_s();
    axi_wr(8'h20, 32'h2, 4'hF, 1);
    axi_rd(8'h20, d);
    chk("set_wins", d[1], 1);
    axi_rd(8'h30, d);
    chk("s_cmd_new", d, s_cmd_in);
    stv[1*STN + 3] = 32'h0000_CAFE;
    axi_rd(8'h8C, d);
    chk("stat_1_3", d, 32'h0000_CAFE);
    axi_rd(8'hA4, d);
    chk("stat_k9", d, 0);
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      chk("irq_lvl", o_irq, |(mr[8][3:0] & mr[9][3:0]));
      case ($urandom % 6)
        0, 1: begin
          idx = ($urandom % 4 == 0) ? $urandom_range(16, 63) : $urandom_range(0, 15);
          s = (idx == 4 || idx == 7 || idx == 8) ? 4'hF : 4'($urandom);
          d = $urandom;
          axi_wr(AW'(idx * 4), d, s, ($urandom % 8) == 0);
          chk_out();
          chk("m_flag", flag_m, idx == 4 && d[0]);
          chk("s_flag", flag_s, idx == 7 && d[0]);
          chk("flags_off", {flag_m2, flag_s2}, 0);
        end
        2: begin
          idx = $urandom_range(0, 63);
          axi_rd(AW'(idx * 4), d);
          chk($sformatf("rd_%0d", idx), d, exp_rd(idx));
        end
        3: pulse_m();
        4: pulse_s();
        default: stv[$urandom_range(0, SN * STN - 1)] = $urandom;
      endcase
    end
    @(negedge clk);
    awaddr = 8'h0C; wdata = 32'hA5A5_0001; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    idx = 0;
    while (!awready && idx < 20) begin @(negedge clk); idx++; end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("pre_rst_bvalid", bvalid, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_async_bvalid", bvalid, 0);
    chk("rst_async_irq", o_irq, 0);
    chk("rst_async_flags", {o_m_sfp_flag, o_s_sfp_rsp_flag}, 0);
    chk_out();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("no_late_b", bvalid, 0);
    axi_wr(8'h04, 32'h3, 4'h1, 0);
    chk_out();
    axi_rd(8'h04, d);
    chk("post_rst_rd", d, 32'h3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
